// File: rtl/rank_pkg.sv
// Shared definitions for the top-K rank scanner: default sizes,
// FSM state encoding and the working-list slot record.
package rank_pkg;

    localparam int RANK_M     = 64;
    localparam int RANK_WIDTH = 16;
    localparam int RANK_K     = 10;
    localparam int RANK_IDW   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } state_t;

    // One entry of the working list. The valid flag is clear for an empty slot.
    typedef struct packed {
        logic                  valid;
        logic [RANK_WIDTH-1:0] val;
        logic [RANK_IDW-1:0]   id;
    } slot_t;

endpackage

// File: rtl/rank_insert_slot.sv
// Single cell of the sorted working list. Each cycle it either accepts the
// incoming entry, inherits the entry from the slot above (shift down) or holds.
module rank_insert_slot
    import rank_pkg::*;
(
    input  slot_t                 i_self,
    input  slot_t                 i_above,
    input  logic                  i_aboveWins,
    input  logic [RANK_WIDTH-1:0] i_newVal,
    input  logic [RANK_IDW-1:0]   i_newId,
    output logic                  o_wins,
    output slot_t                 o_next
);

    logic w_wins;

    // An empty slot loses to anything; a filled slot loses only to a strictly
    // larger value, which keeps equal values in ascending ID order.
    always_comb begin
        w_wins = (!i_self.valid) || (i_self.val < i_newVal);
    end

    // The list is descending with empties at the bottom, so once a slot wins every
    // slot below wins too. The first winner takes the new entry; the ones below shift.
    always_comb begin
        o_next = i_self;
        if (i_aboveWins) begin
            o_next = i_above;
        end else if (w_wins) begin
            o_next.valid = 1'b1;
            o_next.val   = i_newVal;
            o_next.id    = i_newId;
        end
    end

    assign o_wins = w_wins;

endmodule

// File: rtl/rank_topk_scanner.sv
// Sequential top-K selector. It snapshots M node values on start, inserts one node
// per clock into a K-entry sorted list and publishes the list when the scan ends.
// The slot record width is taken from rank_pkg, so WIDTH and IDW must match it.
module rank_topk_scanner
    import rank_pkg::*;
#(
    parameter int M     = RANK_M,
    parameter int WIDTH = RANK_WIDTH,
    parameter int K     = RANK_K,
    parameter int IDW   = RANK_IDW
)
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [M*WIDTH-1:0]   vals,
    output logic                 busy,
    output logic                 done,
    output logic                 result_valid,
    output logic [K*WIDTH-1:0]   top_vals,
    output logic [K*IDW-1:0]     top_ids
);

    state_t               r_state;
    state_t               w_nextState;
    logic [M*WIDTH-1:0]   r_snap;
    logic [IDW-1:0]       r_idx;
    slot_t                r_slots     [K];
    slot_t                w_nextSlots [K];
    logic                 w_wins      [K];
    logic [WIDTH-1:0]     w_newVal;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_resultValid;
    logic [K*WIDTH-1:0]   r_topVals;
    logic [K*IDW-1:0]     r_topIds;

    assign w_newVal = r_snap[int'(r_idx)*WIDTH +: WIDTH];

    // One list cell per rank; cell 0 has nothing above it.
    for (genvar g = 0; g < K; g++) begin : g_slot
        slot_t w_above;
        logic  w_aboveWins;
        if (g == 0) begin : g_head
            assign w_above     = '0;
            assign w_aboveWins = 1'b0;
        end else begin : g_body
            assign w_above     = r_slots[g-1];
            assign w_aboveWins = w_wins[g-1];
        end
        rank_insert_slot u_slot (
            .i_self      (r_slots[g]),
            .i_above     (w_above),
            .i_aboveWins (w_aboveWins),
            .i_newVal    (w_newVal),
            .i_newId     (r_idx),
            .o_wins      (w_wins[g]),
            .o_next      (w_nextSlots[g])
        );
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: idle until start, scan M nodes, spend one cycle publishing.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = SCAN;
            SCAN:    if (r_idx == IDW'(M-1)) w_nextState = FIN;
            FIN:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Datapath: snapshot on accept, insert one node per SCAN cycle, publish in FIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap        <= '0;
            r_idx         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_resultValid <= 1'b0;
            r_topVals     <= '0;
            r_topIds      <= '0;
            for (int k = 0; k < K; k++) begin
                r_slots[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_snap <= vals;
                        r_idx  <= '0;
                        r_busy <= 1'b1;
                        for (int k = 0; k < K; k++) begin
                            r_slots[k] <= '0;
                        end
                    end
                end
                SCAN: begin
                    r_slots <= w_nextSlots;
                    r_idx   <= r_idx + 1'b1;
                end
                FIN: begin
                    for (int k = 0; k < K; k++) begin
                        r_topVals[k*WIDTH +: WIDTH] <= r_slots[k].val;
                        r_topIds[k*IDW +: IDW]      <= r_slots[k].id;
                    end
                    r_done        <= 1'b1;
                    r_resultValid <= 1'b1;
                    r_busy        <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign result_valid = r_resultValid;
    assign top_vals     = r_topVals;
    assign top_ids      = r_topIds;

endmodule

// File: tb/tb_rank_topk_scanner.sv
// Scoreboard bench for rank_topk_scanner. Stimulus pushes the expected ranking
// (from a selection-sort reference) and completion cycle; a monitor pops on done.
module tb_rank_topk_scanner;

    localparam int M   = 64;
    localparam int W   = 16;
    localparam int K   = 10;
    localparam int IDW = 6;
    localparam int CW  = K*W;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [M*W-1:0]   vals = '0;
    logic             busy;
    logic             done;
    logic             result_valid;
    logic [K*W-1:0]   top_vals;
    logic [K*IDW-1:0] top_ids;

    typedef struct {
        logic [K*W-1:0]   v;
        logic [K*IDW-1:0] ids;
        int               doneCycle;
    } exp_t;

    exp_t expQ[$];
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;

    rank_topk_scanner #(.M(M), .WIDTH(W), .K(K), .IDW(IDW)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .vals         (vals),
        .busy         (busy),
        .done         (done),
        .result_valid (result_valid),
        .top_vals     (top_vals),
        .top_ids      (top_ids)
    );

    // Free-running clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: repeatedly pick the largest unused value, lowest ID on ties.
    function automatic void model(input logic [M*W-1:0] vec, output logic [K*W-1:0] ev, output logic [K*IDW-1:0] eid);
        bit used[M];
        int best;
        ev  = '0;
        eid = '0;
        for (int i = 0; i < M; i++) used[i] = 1'b0;
        for (int r = 0; r < K; r++) begin
            best = -1;
            for (int i = 0; i < M; i++) begin
                if (!used[i]) begin
                    if (best < 0) best = i;
                    else if (vec[i*W +: W] > vec[best*W +: W]) best = i;
                end
            end
            used[best] = 1'b1;
            ev[r*W +: W]    = vec[best*W +: W];
            eid[r*IDW +: IDW] = IDW'(best);
        end
    endfunction

    function automatic logic [M*W-1:0] randVec(input int unsigned maxVal);
        logic [M*W-1:0] vec;
        for (int i = 0; i < M; i++) vec[i*W +: W] = W'($urandom_range(0, maxVal));
        return vec;
    endfunction

    // Called just after the edge that accepts start.
    task automatic pushExpected(input logic [M*W-1:0] vec);
        exp_t e;
        model(vec, e.v, e.ids);
        e.doneCycle = cycle + M + 1;
        expQ.push_back(e);
    endtask

    // One scan from idle; optionally scramble vals/start while the DUT is busy.
    task automatic applyStimulus(input logic [M*W-1:0] vec, input bit junk);
        @(negedge clk);
        vals  = vec;
        start = 1'b1;
        @(posedge clk);
        #1;
        pushExpected(vec);
        for (int i = 0; i < M+1; i++) begin
            @(negedge clk);
            if (junk) begin
                vals  = randVec(65535);
                start = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 400 && expQ.size() != 0; i++) @(posedge clk);
        checkOutput("drain_timeout", CW'(expQ.size()), '0);
        expQ.delete();
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, CW'(busy), '0);
        checkOutput({tag, "_done"}, CW'(done), '0);
        checkOutput({tag, "_result_valid"}, CW'(result_valid), '0);
        checkOutput({tag, "_top_vals"}, top_vals, '0);
        checkOutput({tag, "_top_ids"}, CW'(top_ids), '0);
    endtask

    // Monitor: compares each done against the scoreboard, plus latency, busy span
    // and that published outputs held still since the previous done.
    logic [K*W-1:0]   lastVals;
    logic [K*IDW-1:0] lastIds;
    bit               stable;
    int               busyRun;
    exp_t             monE;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            lastVals = top_vals;
            lastIds  = top_ids;
            stable   = 1'b1;
            busyRun  = 0;
        end else begin
            if (busy) busyRun++;
            if (done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", CW'(done), '0);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput("top_vals", top_vals, monE.v);
                    checkOutput("top_ids", CW'(top_ids), CW'(monE.ids));
                    checkOutput("result_valid", CW'(result_valid), CW'(1));
                    checkOutput("busy_at_done", CW'(busy), '0);
                    checkOutput("done_latency", CW'(cycle), CW'(monE.doneCycle));
                    checkOutput("busy_span", CW'(busyRun), CW'(M+1));
                    checkOutput("hold_between_done", CW'(stable), CW'(1));
                end
                lastVals = top_vals;
                lastIds  = top_ids;
                stable   = 1'b1;
                busyRun  = 0;
            end else if (top_vals !== lastVals || top_ids !== lastIds) begin
                stable = 1'b0;
            end
        end
    end

    // Watchdog so a stuck design still ends the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed and random scans in sequence.
    initial begin
        logic [M*W-1:0] vec;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        reset = 1'b0;

        for (int i = 0; i < M; i++) vec[i*W +: W] = W'(i);
        applyStimulus(vec, 1'b0);
        waitDrain();

        for (int i = 0; i < M; i++) vec[i*W +: W] = 16'h0100;
        applyStimulus(vec, 1'b0);
        waitDrain();

        for (int i = 0; i < M; i++) vec[i*W +: W] = W'(1000 - i);
        vec[40*W +: W] = 16'hFFFF;
        vec[7*W +: W]  = 16'h0000;
        applyStimulus(vec, 1'b0);
        waitDrain();

        applyStimulus(randVec(65535), 1'b1);
        waitDrain();

        @(negedge clk);
        vec   = randVec(65535);
        vals  = vec;
        start = 1'b1;
        @(posedge clk);
        #1;
        pushExpected(vec);
        @(negedge clk);
        start = 1'b0;
        repeat (28) @(negedge clk);
        reset = 1'b1;
        expQ.delete();
        @(posedge clk);
        #1;
        checkResetState("midscan_reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < M; i++) vec[i*W +: W] = W'(i);
        applyStimulus(vec, 1'b0);
        waitDrain();

        for (int run = 0; run < 4; run++) begin
            @(negedge clk);
            vec   = randVec(65535);
            vals  = vec;
            start = 1'b1;
            @(posedge clk);
            #1;
            pushExpected(vec);
            for (int i = 0; i < M+1; i++) begin
                @(negedge clk);
                vals = randVec(65535);
            end
        end
        @(negedge clk);
        start = 1'b0;
        waitDrain();

        for (int run = 0; run < 3; run++) begin
            applyStimulus(randVec(7), 1'b0);
            waitDrain();
        end

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
